// File: rtl/line_draw_scheduler_if.sv
// Bundle of the requester, drawer and completion signals of line_draw_scheduler.
// The scheduler connects through the master modport: it grants requesters,
// drives the drawer and reports completions. The environment uses slave.
interface line_draw_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int COORD_W = 11,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*4*COORD_W-1:0] req_coords;
    logic [COORD_W-1:0]           drv_x0;
    logic [COORD_W-1:0]           drv_y0;
    logic [COORD_W-1:0]           drv_x1;
    logic [COORD_W-1:0]           drv_y1;
    logic                         drv_start;
    logic                         drv_done;
    logic                         drv_abort;
    logic                         cmp_valid;
    logic [ID_W-1:0]              cmp_id;
    logic                         cmp_err;

    modport master (
        input  req_valid, req_coords, drv_done,
        output req_ready, drv_x0, drv_y0, drv_x1, drv_y1,
               drv_start, drv_abort, cmp_valid, cmp_id, cmp_err
    );

    modport slave (
        output req_valid, req_coords, drv_done,
        input  req_ready, drv_x0, drv_y0, drv_x1, drv_y1,
               drv_start, drv_abort, cmp_valid, cmp_id, cmp_err
    );
endinterface

// File: rtl/line_draw_scheduler.sv
// Round-robin scheduler sharing one line_drawer engine between NUM_REQ
// requesters. One command is accepted at a time, its endpoints are held on
// the drawer inputs, a start pulse is issued and the drawer's done pulse is
// turned into a completion tagged with the requester ID.
// Optional watchdog: define LINE_TIMEOUT_EN to abort a line that has not
// finished within TIMEOUT_CYCLES cycles of WAIT.
module line_draw_scheduler #(
    parameter int NUM_REQ        = 3,
    parameter int COORD_W        = 11,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    line_draw_scheduler_if.master     bus,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int CW4 = 4 * COORD_W;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] winner;
    logic [CW4-1:0]  win_coords;
    logic            any_valid;
    logic            accept;
    logic            timeout_hit;

    // Winner search: lowest valid index at or above rr_ptr, otherwise wrap to the lowest valid index
    always_comb begin
        logic [ID_W-1:0] win_hi;
        logic [ID_W-1:0] win_lo;
        logic [CW4-1:0]  coords_hi;
        logic [CW4-1:0]  coords_lo;
        logic            found_hi;
        win_hi    = '0;
        win_lo    = '0;
        coords_hi = '0;
        coords_lo = '0;
        found_hi  = 1'b0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any_valid = 1'b1;
                win_lo    = ID_W'(i);
                coords_lo = bus.req_coords[i*CW4 +: CW4];
                if (ID_W'(i) >= rr_ptr) begin
                    found_hi  = 1'b1;
                    win_hi    = ID_W'(i);
                    coords_hi = bus.req_coords[i*CW4 +: CW4];
                end
            end
        end
        winner     = found_hi ? win_hi : win_lo;
        win_coords = found_hi ? coords_hi : coords_lo;
    end

    // Grant is one-hot on the winner only while idle; forced low during reset
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = !reset && (state == IDLE) && any_valid && (winner == ID_W'(i));
        end
    end

    assign accept = (state == IDLE) && any_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; drv_done outside WAIT is ignored
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (bus.drv_done || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Accept latches the winner's endpoints and ID and advances the round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            bus.drv_x0 <= '0;
            bus.drv_y0 <= '0;
            bus.drv_x1 <= '0;
            bus.drv_y1 <= '0;
        end else if (accept) begin
            rr_ptr     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            cur_id     <= winner;
            bus.drv_x0 <= win_coords[4*COORD_W-1 -: COORD_W];
            bus.drv_y0 <= win_coords[3*COORD_W-1 -: COORD_W];
            bus.drv_x1 <= win_coords[2*COORD_W-1 -: COORD_W];
            bus.drv_y1 <= win_coords[COORD_W-1 -: COORD_W];
        end
    end

    assign bus.drv_start = (state == START);
    assign bus.cmp_valid = (state == DONE);
    assign bus.cmp_id    = (state == DONE) ? cur_id : '0;
    assign busy          = (state != IDLE);

`ifdef LINE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // A done pulse on the limit cycle takes priority over the abort
    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !bus.drv_done;

    // Watchdog counter cleared on WAIT entry; remembers whether this line timed out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (state == START) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
                timed_out   <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.drv_abort = timeout_hit;
    assign bus.cmp_err   = (state == DONE) && timed_out;
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built in
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES > 0);

    assign timeout_hit   = 1'b0;
    assign bus.drv_abort = 1'b0;
    assign bus.cmp_err   = 1'b0;
    assign timeout_err   = 1'b0;
`endif
endmodule

// File: doc/line_draw_scheduler.md
Name: line_draw_scheduler

Overview:
- Shares one line_drawer engine between NUM_REQ line-command requesters (e.g. UI overlay, test pattern, host).
- Round-robin arbiter accepts one command at a time and holds the endpoints stable on the drawer inputs. It pulses a start, waits for the drawer's done pulse, then reports completion tagged with the requester ID.
- Sits between the requester blocks and the line_drawer / framebuffer write path.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- COORD_W, 11, width of each coordinate
- ID_W, 2, width of cmp_id; must satisfy 2**ID_W >= NUM_REQ
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_coords  in  NUM_REQ*4*COORD_W  requester i at slice [i*4*COORD_W +: 4*COORD_W], packed {x0,y0,x1,y1} with x0 in the MSBs
- drv_x0, drv_y0, drv_x1, drv_y1  out  COORD_W each  endpoints to drawer
- drv_start  out  1  one-cycle start pulse to drawer
- drv_done  in  1  one-cycle pulse from drawer: last pixel written
- drv_abort  out  1  one-cycle abort pulse to drawer
- cmp_valid  out  1  one-cycle completion pulse
- cmp_id  out  ID_W  requester whose line completed; valid with cmp_valid
- cmp_err  out  1  completion was a timeout; valid with cmp_valid
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state) forces:
  - state to IDLE, rr_ptr to 0
  - every output to 0, including drv_x0..drv_y1, cmp_id, timeout_err
- Reset mid-draw: no completion is reported for the aborted line. The drawer is expected to share the reset.
- States: IDLE, START, WAIT, DONE.
- IDLE: winner is the first requester with req_valid set, searching upward from rr_ptr and wrapping.
  - req_ready is combinational: one-hot on the winner, only while in IDLE and any valid is high.
  - Accept happens when req_valid[i] & req_ready[i]. That edge latches the winner's coords into drv_x0..drv_y1 and the winner index into cur_id.
  - On accept: rr_ptr <= (winner+1) mod NUM_REQ, next state START.
  - No valid: stay in IDLE, rr_ptr unchanged.
- START: drv_start=1 for exactly this cycle. Next state WAIT.
- WAIT: the endpoint outputs are held constant.
  - drv_done=1 moves to DONE.
  - drv_done in IDLE, START or DONE is ignored.
- DONE: cmp_valid=1, cmp_id=cur_id and cmp_err set as described under the optional feature, all for this one cycle. Next state IDLE.
- Latency:
  - accept at cycle N, drv_start at N+1
  - drv_done at cycle M in WAIT gives cmp_valid at M+1
  - next accept no earlier than M+2
- Requester handshake:
  - A requester keeps valid and coords stable until accepted.
  - Dropping valid before accept is legal; that requester simply loses arbitration.
- Degenerate lines (x0==x1 and y0==y1) and reversed endpoints pass through unmodified. The drawer normalises them.
- drv_x0..drv_y1 keep the last command's values in IDLE.

Optional Feature:
- LINE_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without drv_done: drv_abort=1 for one cycle, timeout_err is set (sticky until reset), then DONE with cmp_err=1.
  - drv_done arriving on the same cycle as the limit wins: normal completion with cmp_err=0.
- LINE_TIMEOUT_EN undefined:
  - No counter; WAIT lasts indefinitely.
  - drv_abort, cmp_err and timeout_err are tied to 0.

Test Plan:
- Single command: req0 sends {1,1,12,5} -> req_ready[0] in the same cycle, drv_start one cycle later with drv_x0=1, drv_y0=1, drv_x1=12, drv_y1=5. A drv_done pulse 10 cycles later -> cmp_valid with cmp_id=0 exactly one cycle after.
- Round-robin fairness: req0, req1 and req2 all held valid from reset -> accept order 0,1,2,0; each requester's coords appear on drv_* in its turn.
- Pointer wrap: after req2 is served, only req0 and req2 are valid -> req0 wins.
- No starvation: req1 re-asserts valid immediately after each completion -> req2 is still granted before req1's second grant.
- Reset mid-draw: reset asserted during WAIT -> outputs go to 0 immediately (asynchronously), no cmp_valid, rr_ptr=0. A later drv_done pulse while in IDLE is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=16): drv_done never arrives -> drv_abort at WAIT cycle 16, then cmp_valid=1, cmp_err=1, timeout_err=1 held until reset. Repeat with drv_done on WAIT cycle 16 -> cmp_err=0.
